// File: rtl/online_adder_tester.sv
// Digit-serial test sequencer for radix-2^(C-1) signed-digit online adders.
// Takes one test vector (x, y, expected z) and feeds x/y MSD-first, one digit
// per cycle. After the adder's online delay it compares each returned digit
// with z, then reports pass/fail and keeps saturating pass/fail counts.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; captures x/y/z on start
// S_FEED   | N+DELTA+1 cycles: drive digits (then zero flush), sample res_dig
// S_REPORT | one cycle with done high; result registers already updated
module online_adder_tester #(
  parameter int N     = 6,
  parameter int C     = 3,
  parameter int DELTA = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*C-1:0]          x_in,
  input  logic [N*C-1:0]          y_in,
  input  logic [(N+1)*C-1:0]      z_in,
  input  logic                    clear,
  output logic [C-1:0]            x_dig,
  output logic [C-1:0]            y_dig,
  output logic                    dig_valid,
  input  logic [C-1:0]            res_dig,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [$clog2(N+2)-1:0]  err_idx,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt
);

  localparam int IDX_W = $clog2(N+2);
  localparam int KW    = $clog2(N+DELTA+1);

  // The feed timer counts down from N+DELTA; it reaches N exactly when the
  // first adder output digit is due, so "k_q <= N" marks the sampling window.
  localparam logic [KW-1:0]    K_INIT   = KW'(N+DELTA);
  localparam logic [KW-1:0]    K_SAMPLE = KW'(N);
  localparam logic [IDX_W-1:0] IDX_PASS = IDX_W'(N+1);
  localparam logic [IDX_W-1:0] IDX_N    = IDX_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [N*C-1:0]       x_sh_q, x_sh_d;
  logic [N*C-1:0]       y_sh_q, y_sh_d;
  logic [(N+1)*C-1:0]   z_sh_q, z_sh_d;
  logic                 mis_q, mis_d;
  logic [IDX_W-1:0]     eidx_q, eidx_d;
  logic                 pass_q, pass_d;
  logic [IDX_W-1:0]     err_idx_q, err_idx_d;
  logic [CNT_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;

  logic [C-1:0]         z_top;
  logic                 sample;
  logic                 mis_now;
  logic                 last;
  logic                 pass_now;
  logic [IDX_W-1:0]     j_cur;

  // Operands and expected sum sit in shift registers whose top digit is the
  // one currently in play; zeros shifted in at the bottom give the flush.
  assign z_top    = z_sh_q[(N+1)*C-1 -: C];
  assign sample   = (k_q <= K_SAMPLE);
  assign mis_now  = sample && (res_dig != z_top);
  assign last     = (k_q == '0);
  assign pass_now = !(mis_q || mis_now);
  assign j_cur    = IDX_N - IDX_W'(k_q);

  assign x_dig     = x_sh_q[N*C-1 -: C];
  assign y_dig     = y_sh_q[N*C-1 -: C];
  assign dig_valid = (state_q == S_FEED);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_REPORT);
  assign pass      = pass_q;
  assign err_idx   = err_idx_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      z_sh_q     <= '0;
      mis_q      <= 1'b0;
      eidx_q     <= '0;
      pass_q     <= 1'b0;
      err_idx_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      z_sh_q     <= z_sh_d;
      mis_q      <= mis_d;
      eidx_q     <= eidx_d;
      pass_q     <= pass_d;
      err_idx_q  <= err_idx_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // Next-state logic: sequencing, digit compare and result bookkeeping.
  // Results land on the edge leaving FEED so they are valid alongside done.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    x_sh_d     = x_sh_q;
    y_sh_d     = y_sh_q;
    z_sh_d     = z_sh_q;
    mis_d      = mis_q;
    eidx_d     = eidx_q;
    pass_d     = pass_q;
    err_idx_d  = err_idx_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          k_d     = K_INIT;
          x_sh_d  = x_in;
          y_sh_d  = y_in;
          z_sh_d  = z_in;
          mis_d   = 1'b0;
          eidx_d  = '0;
        end
      end
      S_FEED: begin
        x_sh_d = x_sh_q << C;
        y_sh_d = y_sh_q << C;
        if (sample) begin
          z_sh_d = z_sh_q << C;
        end
        if (mis_now && !mis_q) begin
          mis_d  = 1'b1;
          eidx_d = j_cur;
        end
        if (last) begin
          state_d = S_REPORT;
          pass_d  = pass_now;
          if (mis_q) begin
            err_idx_d = eidx_q;
          end else if (mis_now) begin
            err_idx_d = j_cur;
          end else begin
            err_idx_d = IDX_PASS;
          end
          if (pass_now) begin
            if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear has priority over a count landing on the same edge.
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_online_adder_tester.sv
// Scoreboard bench for online_adder_tester. A stub stands in for the adder
// under test and returns a chosen output digit sequence; the reference model
// derives pass/err_idx/counters directly from that sequence and z.
module tb_online_adder_tester;

  localparam int N        = 6;
  localparam int C        = 3;
  localparam int DELTA    = 2;
  localparam int CNT_W    = 2;
  localparam int IDX_W    = $clog2(N+2);
  localparam int FEED_LEN = N + DELTA + 1;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int DMAX     = (1 << (C-1)) - 1;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [N*C-1:0]         x_in;
  logic [N*C-1:0]         y_in;
  logic [(N+1)*C-1:0]     z_in;
  logic                   clear;
  logic [C-1:0]           x_dig;
  logic [C-1:0]           y_dig;
  logic                   dig_valid;
  logic [C-1:0]           res_dig;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [IDX_W-1:0]       err_idx;
  logic [CNT_W-1:0]       pass_cnt;
  logic [CNT_W-1:0]       fail_cnt;

  online_adder_tester #(.N(N), .C(C), .DELTA(DELTA), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .clear(clear),
    .x_dig(x_dig), .y_dig(y_dig), .dig_valid(dig_valid), .res_dig(res_dig),
    .busy(busy), .done(done), .pass(pass), .err_idx(err_idx),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  typedef struct {
    logic [N*C-1:0]     x;
    logic [N*C-1:0]     y;
    logic [(N+1)*C-1:0] z;
    logic [(N+1)*C-1:0] res;   // adder output digit j at [C*j +: C]
    bit                 exp_pass;
    int                 exp_err;
    int                 exp_pc;
    int                 exp_fc;
    bit                 chk_cnt;
  } sb_t;

  sb_t q[$];
  sb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  mpc = 0;
  int  mfc = 0;
  int  feed_k = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_x_dig"},     32'(x_dig),     0);
    chk({tag, "_y_dig"},     32'(y_dig),     0);
    chk({tag, "_dig_valid"}, 32'(dig_valid), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_pass"},      32'(pass),      0);
    chk({tag, "_err_idx"},   32'(err_idx),   0);
    chk({tag, "_pass_cnt"},  32'(pass_cnt),  0);
    chk({tag, "_fail_cnt"},  32'(fail_cnt),  0);
  endtask

  // Pack digits given MSD first.
  function automatic logic [N*C-1:0] pkx(input int d0, d1, d2, d3, d4, d5);
    return {C'(d0), C'(d1), C'(d2), C'(d3), C'(d4), C'(d5)};
  endfunction

  function automatic logic [(N+1)*C-1:0] pkz(input int d0, d1, d2, d3, d4, d5, d6);
    return {C'(d0), C'(d1), C'(d2), C'(d3), C'(d4), C'(d5), C'(d6)};
  endfunction

  function automatic logic [N*C-1:0] rnd_x();
    logic [N*C-1:0] r;
    for (int i = 0; i < N; i++) r[C*i +: C] = C'($urandom_range(0, 2*DMAX) - DMAX);
    return r;
  endfunction

  function automatic logic [(N+1)*C-1:0] rnd_z();
    logic [(N+1)*C-1:0] r;
    for (int i = 0; i <= N; i++) r[C*i +: C] = C'($urandom_range(0, 2*DMAX) - DMAX);
    return r;
  endfunction

  // Adder output sequence: output digit j is z digit N-j, flipped where mask[j].
  function automatic logic [(N+1)*C-1:0] mk_res(input logic [(N+1)*C-1:0] z, input logic [N:0] mask);
    logic [(N+1)*C-1:0] r;
    for (int j = 0; j <= N; j++) begin
      r[C*j +: C] = z[C*(N-j) +: C];
      if (mask[j]) r[C*j +: C] = r[C*j +: C] ^ C'($urandom_range(1, (1 << C) - 1));
    end
    return r;
  endfunction

  task automatic issue(input logic [N*C-1:0] x, input logic [N*C-1:0] y,
                       input logic [(N+1)*C-1:0] z, input logic [(N+1)*C-1:0] res,
                       input bit chk_cnt);
    sb_t e;
    int  err;
    int  b;
    err = -1;
    for (int j = 0; j <= N; j++)
      if (err < 0 && res[C*j +: C] !== z[C*(N-j) +: C]) err = j;
    b = 0;
    @(negedge clk);
    while (busy && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (busy) begin
      chk("idle_timeout", 32'(busy), 0);
      return;
    end
    e.x = x; e.y = y; e.z = z; e.res = res; e.chk_cnt = chk_cnt;
    e.exp_pass = (err < 0);
    e.exp_err  = (err < 0) ? N + 1 : err;
    if (e.exp_pass) mpc = (mpc == CMAX) ? CMAX : mpc + 1;
    else            mfc = (mfc == CMAX) ? CMAX : mfc + 1;
    e.exp_pc = mpc;
    e.exp_fc = mfc;
    q.push_back(e);
    x_in = x; y_in = y; z_in = z; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in = (N*C)'($urandom);
    y_in = (N*C)'($urandom);
    z_in = ((N+1)*C)'($urandom);
    chk("accept_busy", 32'(busy), 1);
  endtask

  task automatic mid_start();
    repeat (3) @(negedge clk);
    x_in = rnd_x(); y_in = rnd_x(); z_in = rnd_z();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor + adder stub: checks digits fed each cycle, supplies res_dig,
  // and pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (reset) begin
      feed_k = 0;
    end else begin
      chk("busy_vs_phase", 32'(busy), 32'(dig_valid | done));
      if (dig_valid) begin
        if (q.size() == 0) begin
          chk("feed_without_test", 32'(dig_valid), 0);
        end else begin
          mon_e = q[0];
          if (feed_k >= FEED_LEN) begin
            chk("feed_too_long", 32'(feed_k), FEED_LEN - 1);
          end else if (feed_k < N) begin
            chk("x_dig", 32'(x_dig), 32'(mon_e.x[C*(N-1-feed_k) +: C]));
            chk("y_dig", 32'(y_dig), 32'(mon_e.y[C*(N-1-feed_k) +: C]));
          end else begin
            chk("x_flush", 32'(x_dig), 0);
            chk("y_flush", 32'(y_dig), 0);
          end
          if (feed_k >= DELTA && feed_k < FEED_LEN) res_dig = mon_e.res[C*(feed_k-DELTA) +: C];
          else                                      res_dig = C'($urandom);
        end
        feed_k++;
      end else if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 0);
        end else begin
          mon_e = q.pop_front();
          chk("feed_len", 32'(feed_k), FEED_LEN);
          chk("pass", 32'(pass), 32'(mon_e.exp_pass));
          chk("err_idx", 32'(err_idx), 32'(mon_e.exp_err));
          if (mon_e.chk_cnt) begin
            chk("pass_cnt", 32'(pass_cnt), 32'(mon_e.exp_pc));
            chk("fail_cnt", 32'(fail_cnt), 32'(mon_e.exp_fc));
          end
        end
        feed_k = 0;
      end else begin
        feed_k = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [(N+1)*C-1:0] zd;
    logic [N*C-1:0]     xd, yd;
    logic [N:0]         mask;
    int                 b;

    reset = 1'b1; start = 1'b0; clear = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; res_dig = '0;
    #1;
    chk_rst_vals("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_pass_cnt", 32'(pass_cnt), 0);
      chk("idle_fail_cnt", 32'(fail_cnt), 0);
    end

    // All-zero vector: passes with err_idx = N+1.
    issue('0, '0, '0, '0, 1'b1);

    // Directed vector, clean and with output digits 3 and 5 corrupted.
    xd = pkx(1, 2, -3, 3, 0, -1);
    yd = pkx(2, -1, -3, 3, 2, 2);
    zd = pkz(1, -1, 0, -1, 2, 2, 1);
    issue(xd, yd, zd, mk_res(zd, 7'b0000000), 1'b1);
    issue(xd, yd, zd, mk_res(zd, 7'b0101000), 1'b1);

    // start pulsed mid-feed must be ignored.
    issue(xd, yd, zd, mk_res(zd, 7'b0000000), 1'b1);
    mid_start();

    // Reset during feed cycle 4.
    xd = rnd_x(); yd = rnd_x(); zd = rnd_z();
    issue(xd, yd, zd, mk_res(zd, 7'b0000000), 1'b1);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    mpc = 0; mfc = 0;
    #1;
    chk_rst_vals("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done_busy", 32'(busy), 0);

    // Clear coinciding with done.
    issue(xd, yd, zd, mk_res(zd, 7'b0000000), 1'b1);
    xd = rnd_x(); yd = rnd_x(); zd = rnd_z();
    issue(xd, yd, zd, mk_res(zd, 7'b0000100), 1'b0);
    b = 0;
    @(negedge clk);
    while (!done && b < 40) begin
      @(negedge clk);
      b++;
    end
    chk("clear_done_seen", 32'(done), 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    mpc = 0; mfc = 0;
    chk("clear_pass_cnt", 32'(pass_cnt), 0);
    chk("clear_fail_cnt", 32'(fail_cnt), 0);
    chk("clear_pass_held", 32'(pass), 0);
    chk("clear_err_held", 32'(err_idx), 2);

    // Saturation: five passes then one failure.
    for (int i = 0; i < 5; i++) begin
      zd = rnd_z();
      issue(rnd_x(), rnd_x(), zd, mk_res(zd, 7'b0000000), 1'b1);
    end
    zd = rnd_z();
    issue(rnd_x(), rnd_x(), zd, mk_res(zd, 7'b1000000), 1'b1);

    // Randomized tests with random corruption and mid-feed start pulses.
    for (int i = 0; i < 24; i++) begin
      zd = rnd_z();
      mask = ($urandom_range(0, 1) == 0) ? '0 : (N+1)'($urandom);
      issue(rnd_x(), rnd_x(), zd, mk_res(zd, mask), 1'b1);
      if ($urandom_range(0, 3) == 0) mid_start();
    end

    b = 0;
    while (q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
